// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Receive-side decoder for a 4-digit multiplexed seven-segment bus.
// Samples the scanned COM (active-low digit select) and SEG {a..g,dp} lines,
// rebuilds the four displayed decimal digits, and presents the frame as BCD
// and binary with a one-cycle Valid pulse. Err flags illegal samples and
// Timeout flags a link that has stopped producing good samples.
//
// Optional feature macro: SEG_DP_CAPTURE_EN
//   defined   : SEG[0] is stored per digit and presented on DP[3:0]
//   undefined : SEG[0] is ignored entirely and DP is tied to 4'b0000
//
// Latency: pin change to sample is 2 synchronizer cycles + STABLE_CYCLES.
// The fourth digit's sample updates Digit_BCD one cycle later, and
// Value_Bin/Valid one cycle after that.

module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        Sys_CLK,
  input  logic        Sys_RST,
  input  logic [3:0]  COM,
  input  logic [7:0]  SEG,
  output logic [15:0] Digit_BCD,
  output logic [13:0] Value_Bin,
  output logic        Valid,
  output logic        Err,
  output logic        Timeout,
  output logic [3:0]  DP
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_TAKE = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);

  // The dp line only takes part in stability and capture when it is captured.
`ifdef SEG_DP_CAPTURE_EN
  localparam logic [7:0] SEG_KEEP = 8'hFF;
`else
  localparam logic [7:0] SEG_KEEP = 8'hFE;
`endif

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_LATCH   = 2'd1,
    S_CONVERT = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [1:0] idx;
  } com_info_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] digit;
  } seg_info_t;

  // Exactly one low COM line selects a digit; all-high is a blank scan slot.
  function automatic com_info_t decode_com(input logic [3:0] c);
    com_info_t r;
    r = '0;
    case (c)
      4'b1111: r.blank = 1'b1;
      4'b1110: begin r.legal = 1'b1; r.idx = 2'd0; end
      4'b1101: begin r.legal = 1'b1; r.idx = 2'd1; end
      4'b1011: begin r.legal = 1'b1; r.idx = 2'd2; end
      4'b0111: begin r.legal = 1'b1; r.idx = 2'd3; end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Segments {a,b,c,d,e,f,g} to decimal digit; anything else is undecodable.
  function automatic seg_info_t decode_seg(input logic [6:0] s);
    seg_info_t r;
    r.ok = 1'b1;
    case (s)
      7'b1111110: r.digit = 4'd0;
      7'b0110000: r.digit = 4'd1;
      7'b1101101: r.digit = 4'd2;
      7'b1111001: r.digit = 4'd3;
      7'b0110011: r.digit = 4'd4;
      7'b1011011: r.digit = 4'd5;
      7'b1011111: r.digit = 4'd6;
      7'b1110000: r.digit = 4'd7;
      7'b1111111: r.digit = 4'd8;
      7'b1111011: r.digit = 4'd9;
      default: begin
        r.ok    = 1'b0;
        r.digit = 4'd0;
      end
    endcase
    return r;
  endfunction

  // Synchronizers and change detection
  logic [3:0]        com_s1_q, com_s2_q;
  logic [7:0]        seg_s1_q, seg_s2_q;
  logic [11:0]       key_prev_q;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              changed, take;

  // Sample held across LATCH/CONVERT
  logic              pend_q, pend_d;
  logic [3:0]        pend_com_q, pend_com_d;
  logic [6:0]        pend_seg_q, pend_seg_d;

  // Sample presented to the frame logic
  logic              apply;
  logic [3:0]        apply_com;
  logic [6:0]        apply_seg;
  com_info_t         com_info;
  seg_info_t         seg_info;

  // Frame assembly
  state_e            state_q, state_d;
  logic [3:0]        mask_q, mask_d;
  logic              bad_q, bad_d;
  logic              latch_good_q, latch_good_d;
  logic [3:0][3:0]   slot_q, slot_d;
  logic              good, frame_done, to_reach;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  // Output registers
  logic [15:0]       digit_bcd_q, digit_bcd_d;
  logic [13:0]       value_bin_q, value_bin_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;

`ifdef SEG_DP_CAPTURE_EN
  logic              pend_dp_q, pend_dp_d;
  logic              apply_dp;
  logic [3:0]        slot_dp_q, slot_dp_d;
  logic [3:0]        dp_q, dp_d;
`endif

  // Two-flop synchronizers; dp is masked off here when it is not captured.
  always_ff @(posedge Sys_CLK) begin
    // NOTE: every clocked assignment is non-blocking so that all flops see the
    // pre-edge values of each other and the chain shifts one stage per edge.
    if (Sys_RST) begin
      com_s1_q <= 4'hF;
      com_s2_q <= 4'hF;
      seg_s1_q <= 8'h00;
      seg_s2_q <= 8'h00;
    end else begin
      com_s1_q <= COM;
      com_s2_q <= com_s1_q;
      seg_s1_q <= SEG & SEG_KEEP;
      seg_s2_q <= seg_s1_q;
    end
  end

  // Stability counter, sample strobe and hold of a sample that lands outside COLLECT.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would make synthesis infer a latch.
    changed    = ({com_s2_q, seg_s2_q} != key_prev_q);
    stab_d     = stab_q;
    pend_d     = pend_q;
    pend_com_d = pend_com_q;
    pend_seg_d = pend_seg_q;
`ifdef SEG_DP_CAPTURE_EN
    pend_dp_d  = pend_dp_q;
`endif

    if (changed) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end
    take = !changed && (stab_q == STAB_TAKE);

    apply     = (state_q == S_COLLECT) && (take || pend_q);
    apply_com = pend_q ? pend_com_q : com_s2_q;
    apply_seg = pend_q ? pend_seg_q : seg_s2_q[7:1];
`ifdef SEG_DP_CAPTURE_EN
    apply_dp  = pend_q ? pend_dp_q : seg_s2_q[0];
`endif

    if (state_q == S_COLLECT) begin
      pend_d = 1'b0;
    end else if (take) begin
      pend_d     = 1'b1;
      pend_com_d = com_s2_q;
      pend_seg_d = seg_s2_q[7:1];
`ifdef SEG_DP_CAPTURE_EN
      pend_dp_d  = seg_s2_q[0];
`endif
    end
  end

  // Frame FSM: classify samples, fill slots, latch, convert and track timeout.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    bad_d        = bad_q;
    latch_good_d = latch_good_q;
    slot_d       = slot_q;
    digit_bcd_d  = digit_bcd_q;
    value_bin_d  = value_bin_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    good         = 1'b0;
    to_cnt_d     = to_cnt_q;
    com_info     = decode_com(apply_com);
    seg_info     = decode_seg(apply_seg);
`ifdef SEG_DP_CAPTURE_EN
    slot_dp_d    = slot_dp_q;
    dp_d         = dp_q;
`endif

    // Blank slots are ignored; a bad digit still counts as written so the
    // frame completes and is then discarded as a whole.
    if (apply && !com_info.blank) begin
      if (!com_info.legal) begin
        err_d = 1'b1;
      end else begin
        mask_d[com_info.idx] = 1'b1;
        if (seg_info.ok) begin
          good                 = 1'b1;
          slot_d[com_info.idx] = seg_info.digit;
`ifdef SEG_DP_CAPTURE_EN
          slot_dp_d[com_info.idx] = apply_dp;
`endif
        end else begin
          bad_d = 1'b1;
          err_d = 1'b1;
        end
      end
    end

    // Completion is judged on the post-sample mask so Digit_BCD is visible
    // during the LATCH cycle itself.
    frame_done = (state_q == S_COLLECT) && (mask_d == 4'hF);

    case (state_q)
      S_COLLECT: begin
        if (frame_done) begin
          state_d      = S_LATCH;
          latch_good_d = !bad_d;
          if (!bad_d) begin
            digit_bcd_d = slot_d;
`ifdef SEG_DP_CAPTURE_EN
            dp_d        = slot_dp_d;
`endif
          end
          mask_d = '0;
          bad_d  = 1'b0;
        end
      end
      S_LATCH: begin
        if (latch_good_q) begin
          state_d     = S_CONVERT;
          valid_d     = 1'b1;
          value_bin_d = 14'(digit_bcd_q[15:12]) * 14'd1000
                      + 14'(digit_bcd_q[11:8])  * 14'd100
                      + 14'(digit_bcd_q[7:4])   * 14'd10
                      + 14'(digit_bcd_q[3:0]);
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_CONVERT: state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase

    // Any good sample restarts the timeout; reaching the limit drops the
    // partial frame so a stale half-frame cannot combine with a new one.
    if (good) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    to_reach  = (to_cnt_d == TO_MAX) && (to_cnt_q != TO_MAX);
    timeout_d = (to_cnt_d == TO_MAX);
    if (to_reach) begin
      mask_d = '0;
      bad_d  = 1'b0;
    end
  end

  // Control and output state registers.
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      key_prev_q   <= {4'hF, 8'h00};
      stab_q       <= '0;
      pend_q       <= 1'b0;
      pend_com_q   <= 4'hF;
      pend_seg_q   <= '0;
      state_q      <= S_COLLECT;
      mask_q       <= '0;
      bad_q        <= 1'b0;
      latch_good_q <= 1'b0;
      to_cnt_q     <= '0;
      digit_bcd_q  <= '0;
      value_bin_q  <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      key_prev_q   <= {com_s2_q, seg_s2_q};
      stab_q       <= stab_d;
      pend_q       <= pend_d;
      pend_com_q   <= pend_com_d;
      pend_seg_q   <= pend_seg_d;
      state_q      <= state_d;
      mask_q       <= mask_d;
      bad_q        <= bad_d;
      latch_good_q <= latch_good_d;
      to_cnt_q     <= to_cnt_d;
      digit_bcd_q  <= digit_bcd_d;
      value_bin_q  <= value_bin_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
    end
  end

  // Digit slot storage.
  always_ff @(posedge Sys_CLK) begin
    // NOTE: slots are deliberately left out of reset; the mask decides which
    // entries are meaningful, and reset clears the mask.
    slot_q <= slot_d;
  end

`ifdef SEG_DP_CAPTURE_EN
  // Per-digit decimal point capture and presentation.
  always_ff @(posedge Sys_CLK) begin
    slot_dp_q <= slot_dp_d;
    if (Sys_RST) begin
      pend_dp_q <= 1'b0;
      dp_q      <= '0;
    end else begin
      pend_dp_q <= pend_dp_d;
      dp_q      <= dp_d;
    end
  end

  assign DP = dp_q;
`else
  assign DP = 4'b0000;
`endif

  assign Digit_BCD = digit_bcd_q;
  assign Value_Bin = value_bin_q;
  assign Valid     = valid_q;
  assign Err       = err_q;
  assign Timeout   = timeout_q;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side decoder for the 4-digit multiplexed seven-segment bus (COM digit select, active-low; SEG segments a..g,dp, active-high, bit 7 = a, bit 0 = dp). It samples the scanned COM/SEG lines, rebuilds the four displayed decimal digits, and presents the value as BCD and binary with a one-cycle valid pulse. It sits at the far end of a display-driver link and serves as a loopback checker and as a capture block for display outputs from external boards.

## Interface
- STABLE_CYCLES, 64: cycles the synchronized {COM,SEG} must stay unchanged before one sample is taken (≥2)
- TIMEOUT_CYCLES, 1000000: cycles without a successful sample before Timeout asserts
- Sys_CLK  in  1  system clock; the only clock
- Sys_RST  in  1  reset, synchronous, active-high
- COM  in  4  digit select, active-low; 1110 = digit 0 (ones) … 0111 = digit 3 (thousands)
- SEG  in  8  segment lines {a,b,c,d,e,f,g,dp}
- Digit_BCD  out  16  {d3,d2,d1,d0}, last complete good frame
- Value_Bin  out  14  binary value of Digit_BCD (0–9999)
- Valid  out  1  one-cycle pulse when Digit_BCD/Value_Bin update
- Err  out  1  one-cycle pulse on an illegal COM or SEG sample
- Timeout  out  1  level; no successful sample for TIMEOUT_CYCLES
- DP  out  4  per-digit decimal point of last good frame (see Configuration)

## Operation
- COM and SEG pass through 2-flop synchronizers; all further logic uses the synchronized values.
- Stability counter: cleared when synchronized {COM,SEG} differs from the previous cycle, otherwise increments and saturates at STABLE_CYCLES. Exactly one sample is taken in the cycle the counter reaches STABLE_CYCLES.
- Sample classification:
  - COM = 1111: blank, ignored; no Err, no slot written.
  - COM with exactly one 0: legal; SEG[7:1] decoded: 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - Any other COM, or an undecodable SEG[7:1]: Err pulse. For a legal COM, the slot is marked written and the frame is marked bad.
- Frame assembly (FSM COLLECT → LATCH → CONVERT → COLLECT):
  - COLLECT: a good sample writes its slot and sets mask[slot]. Rewriting an already-set slot overwrites it. When mask = 1111, go to LATCH.
  - LATCH, 1 cycle:
    - Good frame: Digit_BCD (and DP) load from the slots.
    - Bad frame: nothing loads and the FSM returns to COLLECT.
    - In both cases mask and the bad flag clear.
  - CONVERT, 1 cycle: Value_Bin = d3·1000 + d2·100 + d1·10 + d0, computed in 14 bits with no overflow possible. Valid pulses in this cycle. Return to COLLECT.
  - A sample arriving during LATCH/CONVERT is impossible (STABLE_CYCLES ≥ 2 with its change gap). If one does arrive, it is held and applied on return to COLLECT.
- Timeout: counter clears on every good sample, otherwise saturates at TIMEOUT_CYCLES.
  - At TIMEOUT_CYCLES: Timeout = 1, mask and bad flag clear.
  - Timeout drops on the next good sample.
  - Outputs keep the last good frame throughout.

## Timing
- Reset values: Digit_BCD 0, Value_Bin 0, Valid 0, Err 0, Timeout 0, DP 0. FSM in COLLECT; mask, bad flag and both counters 0.
- Reset mid-frame discards partial slots; the first frame after reset needs all four digits again.
- Pin change to sample: 2 (sync) + STABLE_CYCLES cycles.
- Fourth-digit sample at cycle T: Digit_BCD updates at T+1; Value_Bin and Valid at T+2. Err is registered and fires at T+1 of the offending sample.
- Valid, Value_Bin and Digit_BCD are coherent from T+2 onward.

## Configuration
- SEG_DP_CAPTURE_EN defined: SEG[0] is stored per slot and copied to DP[3:0] with Digit_BCD in LATCH; dp never affects decode.
- SEG_DP_CAPTURE_EN undefined: the port stays present with DP tied to 4'b0000; SEG[0] is ignored entirely.

## Test plan
- Scan value 1234, 200 cycles per digit, digits 0→3, STABLE_CYCLES=64 → Valid once per frame; Digit_BCD=16'h1234; Value_Bin=1234 exactly 2 cycles after the fourth sample.
- Scan 9999, then 0000 → Value_Bin 9999, then 0; one Valid per frame; Err never asserts.
- Digit 2 SEG = 8'b10010010 (undecodable) → one Err pulse; that frame produces no Valid and outputs hold the previous value. The next clean frame updates normally.
- COM = 1100 for 100 cycles → one Err pulse, mask unchanged. COM = 1111 → no Err, no slot written.
- Glitch: SEG toggles every 10 cycles while COM = 1110 → no sample, no Err. Then scanning stops for TIMEOUT_CYCLES → Timeout=1. A good sample clears it.
- Sys_RST for 1 cycle after 3 of 4 digits → all outputs 0; Valid only after four new digits. With SEG_DP_CAPTURE_EN defined and dp set on digit 1 → DP=4'b0010.
